fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_pkg.sv | 13 +
 rtl/fifo_rd_stream.sv | 94 +++++++++
 tb/tb_fifo_rd_stream.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared encodings and default widths for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } cnt_t;

    localparam int DSIZE_DEF = 8;
    localparam int CNTW_DEF  = 16;

endpackage

// File: rtl/fifo_rd_stream.sv
// FIFO pop interface to registered valid/ready stream through a 2-entry buffer.
// Optional popped-word counter port rd_count enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    parameter int CNTW  = CNTW_DEF
`endif
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNTW-1:0]  rd_count
`endif
);

    cnt_t             cnt, cnt_nxt;
    logic [DSIZE-1:0] buf0, buf1, buf0_nxt, buf1_nxt;
    logic             pop;

    // Pop decision uses only local state and FIFO flags; m_ready never reaches it.
    // Masked by rrst so no pop is signalled while the block is held in reset.
    assign rinc    = !rrst && !rempty && (cnt != CNT_TWO) && !flush;
    assign pop     = m_valid && m_ready;
    assign m_valid = (cnt != CNT_EMPTY);
    assign m_data  = buf0;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt  <= CNT_EMPTY;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            cnt  <= cnt_nxt;
            buf0 <= buf0_nxt;
            buf1 <= buf1_nxt;
        end
    end

    always_comb begin
        cnt_nxt  = cnt;
        buf0_nxt = buf0;
        buf1_nxt = buf1;
        unique case (cnt)
            CNT_EMPTY: begin
                if (rinc) begin
                    cnt_nxt  = CNT_ONE;
                    buf0_nxt = rdata;
                end
            end
            CNT_ONE: begin
                if (rinc && !pop) begin
                    cnt_nxt  = CNT_TWO;
                    buf1_nxt = rdata;
                end else if (rinc && pop) begin
                    buf0_nxt = rdata;
                end else if (pop) begin
                    cnt_nxt  = CNT_EMPTY;
                end
            end
            CNT_TWO: begin
                if (pop) begin
                    cnt_nxt  = CNT_ONE;
                    buf0_nxt = buf1;
                end
            end
            default: cnt_nxt = CNT_EMPTY;
        endcase
        if (flush) begin
            cnt_nxt = CNT_EMPTY;
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rd_count <= '0;
        end else if (rinc) begin
            rd_count <= rd_count + CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and random checks of fifo_rd_stream against a queue-level model.
// Counter checks are compiled in when FIFO_RD_STREAM_CNT_EN is defined.
module tb_fifo_rd_stream;

    localparam int DW      = 8;
    localparam int TB_CNTW = 4;

    logic          rclk = 1'b0;
    logic          rrst;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          flush;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [TB_CNTW-1:0] rd_count;
`endif

    fifo_rd_stream #(
        .DSIZE (DW)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .CNTW  (TB_CNTW)
`endif
    ) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .rd_count(rd_count)
`endif
    );

    always #5 rclk = ~rclk;

    // fifo: words still in the upstream FIFO; mq: words the adapter should hold, head first.
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] mq[$];
    int unsigned   mcount;
    int unsigned   checks;
    int unsigned   errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at edge+1, check at edge+3, advance the model at the edge.
    task automatic cyc(input logic fl, input logic rdy);
        logic exp_rinc;
        flush   = fl;
        m_ready = rdy;
        rempty  = (fifo.size() == 0);
        rdata   = rempty ? '0 : fifo[0];
        #2;
        exp_rinc = !rempty && (mq.size() < 2) && !fl;
        chk("rinc", 32'(rinc), 32'(exp_rinc));
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("rd_count", 32'(rd_count), mcount % (1 << TB_CNTW));
`endif
        @(posedge rclk);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (fl) mq.delete();
        if (exp_rinc) begin
            mq.push_back(fifo.pop_front());
            mcount++;
        end
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        fifo.delete();
        mcount = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rrst    = 1'b1;
        rempty  = 1'b1;
        rdata   = '0;
        flush   = 1'b0;
        m_ready = 1'b0;
        #3;
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_rinc", 32'(rinc), 32'd0);
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        repeat (2) cyc(1'b0, 1'b1);

        // Streaming 0x01..0x08 with continuous ready
        for (int i = 1; i <= 8; i++) fifo.push_back(DW'(i));
        repeat (11) cyc(1'b0, 1'b1);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("stream_rd_count", 32'(rd_count), 32'd8);
`endif

        // Backpressure then release
        for (int i = 0; i < 4; i++) fifo.push_back(DW'(8'hA0 + i));
        repeat (4) cyc(1'b0, 1'b0);
        chk("bp_head_held", 32'(m_data), 32'hA0);
        chk("bp_fifo_kept", 32'(fifo.size()), 32'd2);
        repeat (6) cyc(1'b0, 1'b1);

        // Single word at the empty boundary
        fifo.push_back(8'h5A);
        repeat (4) cyc(1'b0, 1'b1);

        // Flush with two words buffered, next FIFO word delivered afterwards
        fifo.push_back(8'h11);
        fifo.push_back(8'h22);
        fifo.push_back(8'h33);
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("flush_fifo_left", 32'(fifo.size()), 32'd1);
        cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);

        // Randomized traffic, readiness and occasional flush
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) fifo.push_back(DW'($urandom));
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (12) cyc(1'b0, 1'b1);

        // Asynchronous reset while the buffer is full
        fifo.push_back(8'hC1);
        fifo.push_back(8'hC2);
        fifo.push_back(8'hC3);
        repeat (3) cyc(1'b0, 1'b0);
        rempty = 1'b0;
        rdata  = fifo[0];
        #2;
        rrst = 1'b1;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_m_data", 32'(m_data), 32'd0);
        chk("arst_rinc", 32'(rinc), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("arst_rd_count", 32'(rd_count), 32'd0);
`endif
        model_reset();
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        repeat (3) cyc(1'b0, 1'b1);
        chk("post_reset_m_data", 32'(m_data), 32'd0);

        // Seventeen pops wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) fifo.push_back(DW'(8'h40 + i));
        repeat (20) cyc(1'b0, 1'b1);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("wrap_rd_count", 32'(rd_count), 32'd1);
`endif
        chk("wrap_all_popped", 32'(fifo.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
